partition_err_profiler: RTL

- Sequential error-characterisation stage that sits directly downstream of an approximate BMF partition (a w/h pair such as a 6-in/4-out multiplier slice) and of its exact counterpart.
- On request, it sweeps every input vector of the partition, drives those vectors to both copies, and consumes their outputs.
- It accumulates error-rate, Hamming-distance and absolute-value error metrics, which the partition flow uses to accept or reject a factorisation rank k.

---
 rtl/partition_err_profiler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/partition_err_profiler.sv
// Error profiler for an approximate partition: sweeps all input vectors and accumulates
// error-rate, Hamming and absolute-error metrics. Optional histogram: define ERR_HIST_EN.
module partition_err_profiler #(
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 4,
  parameter int DUT_LAT = 0,
  parameter int ACC_W   = NUM_IN + NUM_OUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_IN-1:0]            pi,
  input  logic [NUM_OUT-1:0]           po_approx,
  input  logic [NUM_OUT-1:0]           po_exact,
  output logic [NUM_IN:0]              err_cnt,
  output logic [ACC_W-1:0]             ham_sum,
  output logic [ACC_W-1:0]             abs_sum,
  output logic [NUM_OUT-1:0]           max_abs
`ifdef ERR_HIST_EN
  ,
  input  logic [$clog2(NUM_OUT+1)-1:0] hist_sel,
  output logic [NUM_IN:0]              hist_cnt
`endif
);

  localparam int HW = $clog2(NUM_OUT + 1);
  localparam int CW = NUM_IN + 1;
  // Valid pipe is kept at least one bit wide so the combinational case needs no special port.
  localparam int PL = (DUT_LAT > 0) ? DUT_LAT : 1;
  localparam logic [NUM_IN-1:0] PI_LAST  = {NUM_IN{1'b1}};
  localparam logic [NUM_IN-1:0] PI_ONE   = NUM_IN'(1);
  localparam logic [PL-1:0]     LOW_MASK = {PL{1'b1}} >> 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t               state_r;
  logic [NUM_IN-1:0]    pi_r;
  logic                 busy_r;
  logic                 done_r;
  logic [CW-1:0]        err_cnt_r;
  logic [ACC_W-1:0]     ham_sum_r;
  logic [ACC_W-1:0]     abs_sum_r;
  logic [NUM_OUT-1:0]   max_abs_r;
  logic [PL-1:0]        vld_r;

  logic [NUM_OUT-1:0]   diff_s;
  logic [NUM_OUT:0]     sub_s;
  logic [NUM_OUT-1:0]   abs_s;
  logic [HW-1:0]        ham_s;
  logic                 sample_s;
  logic                 tok_s;
  logic                 start_acc_s;
  logic                 drain_last_s;

  function automatic logic [HW-1:0] popcount(input logic [NUM_OUT-1:0] v);
    logic [HW-1:0] c;
    c = {HW{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      c = c + HW'(v[i]);
    end
    return c;
  endfunction

  assign start_acc_s  = (state_r == ST_IDLE) && start;
  assign drain_last_s = ((vld_r & LOW_MASK) == {PL{1'b0}});

  // Per-sample error terms and the sample strobe.
  always_comb begin
    diff_s = po_approx ^ po_exact;
    ham_s  = popcount(diff_s);
    sub_s  = {1'b0, po_approx} - {1'b0, po_exact};
    if (sub_s[NUM_OUT]) begin
      abs_s = NUM_OUT'(-sub_s);
    end else begin
      abs_s = sub_s[NUM_OUT-1:0];
    end
    if (DUT_LAT == 0) begin
      sample_s = (state_r == ST_SWEEP);
      tok_s    = 1'b0;
    end else begin
      sample_s = vld_r[PL-1];
      tok_s    = (state_r == ST_SWEEP);
    end
  end

  // Valid token shift register matching the partition latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {PL{1'b0}};
    end else begin
      vld_r[0] <= tok_s;
      for (int i = 1; i < PL; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Sweep controller and metric accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pi_r      <= {NUM_IN{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_cnt_r <= {CW{1'b0}};
      ham_sum_r <= {ACC_W{1'b0}};
      abs_sum_r <= {ACC_W{1'b0}};
      max_abs_r <= {NUM_OUT{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= ST_SWEEP;
            pi_r      <= {NUM_IN{1'b0}};
            busy_r    <= 1'b1;
            err_cnt_r <= {CW{1'b0}};
            ham_sum_r <= {ACC_W{1'b0}};
            abs_sum_r <= {ACC_W{1'b0}};
            max_abs_r <= {NUM_OUT{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (pi_r == PI_LAST) begin
            if (DUT_LAT > 0) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_FIN;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            pi_r <= pi_r + PI_ONE;
          end
        end
        ST_DRAIN: begin
          // Leave once the token now at the pipe output is the only one left.
          if (drain_last_s) begin
            state_r <= ST_FIN;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase

      if (sample_s) begin
        err_cnt_r <= err_cnt_r + CW'(diff_s != {NUM_OUT{1'b0}});
        ham_sum_r <= ham_sum_r + ACC_W'(ham_s);
        abs_sum_r <= abs_sum_r + ACC_W'(abs_s);
        if (abs_s > max_abs_r) begin
          max_abs_r <= abs_s;
        end else begin
          max_abs_r <= max_abs_r;
        end
      end
    end
  end

  assign pi      = pi_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err_cnt = err_cnt_r;
  assign ham_sum = ham_sum_r;
  assign abs_sum = abs_sum_r;
  assign max_abs = max_abs_r;

`ifdef ERR_HIST_EN
  localparam logic [HW-1:0] HMAX = HW'(NUM_OUT);

  logic [CW-1:0] hist_r [NUM_OUT+1];

  // Histogram of per-sample Hamming distance.
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      for (int h = 0; h <= NUM_OUT; h++) begin
        hist_r[h] <= {CW{1'b0}};
      end
    end else if (sample_s) begin
      hist_r[ham_s] <= hist_r[ham_s] + CW'(1);
    end else begin
      for (int h = 0; h <= NUM_OUT; h++) begin
        hist_r[h] <= hist_r[h];
      end
    end
  end

  // Bin readout; out-of-range selects read as zero.
  always_comb begin
    if (hist_sel <= HMAX) begin
      hist_cnt = hist_r[hist_sel];
    end else begin
      hist_cnt = {CW{1'b0}};
    end
  end
`endif

endmodule
